// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared FSM encoding, default sizing and roll-step helper for the dice bank
package dice_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    ROLLING = 1'b1
  } state_t;

  localparam int DEF_N_DICE      = 5;
  localparam int DEF_MAX         = 5;
  localparam int DEF_W           = 3;
  localparam int DEF_ROLL_CYCLES = 4;

  // Per-die roll increment; distinct steps keep the dice from moving in lockstep.
  function automatic int roll_step(input int idx, input int max_val);
    return (idx % max_val) + 1;
  endfunction

endpackage

// File: rtl/dice_mod_step.sv
// rtl/dice_mod_step.sv - combinational add/subtract of a step modulo MAX+1
module dice_mod_step #(
  parameter int MAX = 5,
  parameter int W   = 3
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] step,
  input  logic         up,
  output logic [W-1:0] next
);

  logic [W:0] sum;
  logic [W:0] diff;

  // value and step are both in 0..MAX, so one conditional correction is enough.
  always_comb begin
    sum  = {1'b0, value} + {1'b0, step};
    diff = '0;
    if (value >= step) begin
      diff = {1'b0, value} - {1'b0, step};
    end else begin
      diff = {1'b0, value} + (W+1)'(MAX + 1) - {1'b0, step};
    end
    next = '0;
    if (up) begin
      if (sum > (W+1)'(MAX)) begin
        next = W'(sum - (W+1)'(MAX + 1));
      end else begin
        next = sum[W-1:0];
      end
    end else begin
      next = diff[W-1:0];
    end
  end

endmodule

// File: rtl/dice_bank.sv
// rtl/dice_bank.sv - registered bank of modulo dice with selection, per-die lock and timed roll
module dice_bank
  import dice_pkg::*;
#(
  parameter int N_DICE      = DEF_N_DICE,
  parameter int MAX         = DEF_MAX,
  parameter int W           = DEF_W,
  parameter int ROLL_CYCLES = DEF_ROLL_CYCLES,
  parameter int SW          = $clog2(N_DICE)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                inc,
  input  logic                dec,
  input  logic                sel_next,
  input  logic                lock_tgl,
  input  logic                roll,
  output logic [N_DICE*W-1:0] dice,
  output logic [SW-1:0]       sel,
  output logic [N_DICE-1:0]   lock,
  output logic                busy,
  output logic                done
);

  localparam int CW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] roll_cnt;
  logic          rolling;
  logic [W-1:0]  next_val [N_DICE];

  assign rolling = (state == ROLLING);

  // One stepper per die: unit step up/down in IDLE, the die's own roll step while rolling.
  for (genvar i = 0; i < N_DICE; i++) begin : g_die
    localparam logic [W-1:0] ROLL_STEP = W'(roll_step(i, MAX));

    logic [W-1:0] step;
    logic         up;

    assign step = rolling ? ROLL_STEP : W'(1);
    assign up   = rolling | inc;

    dice_mod_step #(
      .MAX (MAX),
      .W   (W)
    ) u_step (
      .value (dice[i*W +: W]),
      .step  (step),
      .up    (up),
      .next  (next_val[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      roll_cnt <= '0;
      dice     <= '0;
      sel      <= '0;
      lock     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (roll) begin
            state    <= ROLLING;
            busy     <= 1'b1;
            roll_cnt <= CW'(ROLL_CYCLES - 1);
          end else begin
            // Step and toggle both act on the old selection and the old lock value.
            for (int i = 0; i < N_DICE; i++) begin
              if ((inc ^ dec) && (sel == SW'(i)) && !lock[i]) begin
                dice[i*W +: W] <= next_val[i];
              end
              if (lock_tgl && (sel == SW'(i))) begin
                lock[i] <= ~lock[i];
              end
            end
            if (sel_next) begin
              sel <= (sel == SW'(N_DICE - 1)) ? '0 : sel + 1'b1;
            end
          end
        end

        ROLLING: begin
          for (int i = 0; i < N_DICE; i++) begin
            if (!lock[i]) begin
              dice[i*W +: W] <= next_val[i];
            end
          end
          if (roll_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            roll_cnt <= roll_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_bank.sv
// tb/tb_dice_bank.sv - directed and randomized self-checking bench for dice_bank
module tb_dice_bank;

  localparam int N  = 5;
  localparam int MX = 5;
  localparam int W  = 3;
  localparam int R  = 4;
  localparam int SW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           inc = 1'b0;
  logic           dec = 1'b0;
  logic           sel_next = 1'b0;
  logic           lock_tgl = 1'b0;
  logic           roll = 1'b0;
  logic [N*W-1:0] dice;
  logic [SW-1:0]  sel;
  logic [N-1:0]   lock;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_pass   = 0;

  int mv [N];
  bit ml [N];
  int msel;
  int mleft;
  bit mbusy;
  bit mdone;

  always #5 clk = ~clk;

  dice_bank #(
    .N_DICE      (N),
    .MAX         (MX),
    .W           (W),
    .ROLL_CYCLES (R)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (inc),
    .dec      (dec),
    .sel_next (sel_next),
    .lock_tgl (lock_tgl),
    .roll     (roll),
    .dice     (dice),
    .sel      (sel),
    .lock     (lock),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pack_dice();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(mv[i]);
    return r;
  endfunction

  function automatic logic [31:0] pack_lock();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = ml[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      ml[i] = 1'b0;
    end
    msel  = 0;
    mleft = 0;
    mbusy = 1'b0;
    mdone = 1'b0;
  endtask

  // Reference behaviour: a roll is R whole steps; each die moves by (i mod MAX)+1 per step.
  task automatic model_edge(input bit a_inc, input bit a_dec, input bit a_sn, input bit a_lt, input bit a_roll);
    mdone = 1'b0;
    if (mleft > 0) begin
      for (int i = 0; i < N; i++)
        if (!ml[i]) mv[i] = (mv[i] + (i % MX) + 1) % (MX + 1);
      mleft--;
      if (mleft == 0) begin
        mbusy = 1'b0;
        mdone = 1'b1;
      end
    end else if (a_roll) begin
      mleft = R;
      mbusy = 1'b1;
    end else begin
      if (a_inc && !a_dec && !ml[msel]) mv[msel] = (mv[msel] + 1) % (MX + 1);
      if (a_dec && !a_inc && !ml[msel]) mv[msel] = (mv[msel] + MX) % (MX + 1);
      if (a_lt) ml[msel] = !ml[msel];
      if (a_sn) msel = (msel + 1) % N;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dice"}, 32'(dice), pack_dice());
    check({tag, "_sel"},  32'(sel),  32'(msel));
    check({tag, "_lock"}, 32'(lock), pack_lock());
    check({tag, "_busy"}, 32'(busy), 32'(mbusy));
    check({tag, "_done"}, 32'(done), 32'(mdone));
  endtask

  task automatic step(input string tag, input bit a_inc, input bit a_dec, input bit a_sn,
                      input bit a_lt, input bit a_roll);
    inc = a_inc; dec = a_dec; sel_next = a_sn; lock_tgl = a_lt; roll = a_roll;
    @(posedge clk);
    model_edge(a_inc, a_dec, a_sn, a_lt, a_roll);
    #1;
    inc = 1'b0; dec = 1'b0; sel_next = 1'b0; lock_tgl = 1'b0; roll = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [31:0] saved;
  int          busy_cycles;

  initial begin
    model_reset();
    do_reset();

    for (int k = 0; k < 6; k++) begin
      step("inc6", 1, 0, 0, 0, 0);
      check("inc6_die0", 32'(dice[2:0]), 32'((k + 1) % 6));
    end
    check("inc6_others", 32'(dice[N*W-1:W]), 32'd0);

    do_reset();
    step("dec", 0, 1, 0, 0, 0);
    check("dec_wrap", 32'(dice[2:0]), 32'd5);
    step("incdec", 1, 1, 0, 0, 0);
    check("incdec_hold", 32'(dice[2:0]), 32'd5);

    for (int k = 0; k < 5; k++) begin
      step("seln", 0, 0, 1, 0, 0);
      check("seln_val", 32'(sel), 32'((k + 1) % 5));
    end
    step("inc_seln", 1, 0, 1, 0, 0);
    check("inc_seln_die0", 32'(dice[2:0]), 32'd0);
    check("inc_seln_sel", 32'(sel), 32'd1);

    do_reset();
    step("to2", 0, 0, 1, 0, 0);
    step("to2", 0, 0, 1, 0, 0);
    step("lock2", 0, 0, 0, 1, 0);
    check("lock2_flag", 32'(lock), 32'h4);
    step("roll", 0, 0, 0, 0, 1);
    busy_cycles = busy ? 1 : 0;
    for (int k = 0; k < R; k++) begin
      step("rolling", (k == 0), 0, 0, (k == 1), (k == 2));
      if (busy) busy_cycles++;
    end
    check("roll_busy_cycles", 32'(busy_cycles), 32'(R));
    check("roll_done", 32'(done), 32'd1);
    check("roll_final", 32'(dice), 32'(15'b010_100_000_010_100));
    check("roll_lock_kept", 32'(lock), 32'h4);
    step("after_done", 0, 0, 0, 0, 0);
    check("done_one_cycle", 32'(done), 32'd0);

    step("roll2", 0, 0, 0, 0, 1);
    step("roll2", 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midroll_rst");
    check("midroll_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_all("rst_held");
    reset_n = 1'b1;
    step("roll3", 0, 0, 0, 0, 1);
    for (int k = 0; k < R; k++) step("roll3", 0, 0, 0, 0, 0);
    check("roll3_done", 32'(done), 32'd1);

    for (int k = 0; k < N; k++) step("lockall", 0, 0, 1, 1, 0);
    check("lockall_flags", 32'(lock), 32'h1f);
    saved = 32'(dice);
    step("lroll", 0, 0, 0, 0, 1);
    busy_cycles = busy ? 1 : 0;
    for (int k = 0; k < R; k++) begin
      step("lroll", 0, 0, 0, 0, 0);
      if (busy) busy_cycles++;
    end
    check("lroll_busy_cycles", 32'(busy_cycles), 32'(R));
    check("lroll_done", 32'(done), 32'd1);
    check("lroll_unchanged", 32'(dice), saved);

    for (int k = 0; k < 600; k++) begin
      step("rand",
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 11) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
